// File: rtl/projectile_scheduler_if.sv
// -----------------------------------------------------------------------------
// projectile_scheduler_if
//
// Purpose: bundles the fire handshake, collision kill, frame/status and
// per-pixel render/ROM signals of the projectile scheduler. Clock and reset
// remain plain module ports.
//
// Signals:
//   frame_tick   one-cycle pulse per frame (vblank)
//   fire_req     fire request, held until fire_ack
//   fire_x/y     spawn position (left/top edge), sampled on ack
//   fire_ack     one-cycle pulse, slot allocated
//   hit_clear    per-slot kill from collision logic
//   active_mask  registered per-slot active flags
//   busy         high while slots are being advanced
//   pixel_x/y    current VGA pixel
//   video_on     visible-region flag
//   rom_row/col  sprite ROM address (registered)
//   rom_color    sprite ROM data, one cycle after the address
//   pix_color    projectile color for the mixer
//   pix_valid    projectile pixel present
//
// Modports:
//   master  environment side (frame timing, requester, collision, VGA, ROM)
//   slave   scheduler side
// -----------------------------------------------------------------------------
interface projectile_scheduler_if #(
    parameter int NUM_SLOTS = 4
);
    logic                 frame_tick;
    logic                 fire_req;
    logic [9:0]           fire_x;
    logic [9:0]           fire_y;
    logic                 fire_ack;
    logic [NUM_SLOTS-1:0] hit_clear;
    logic [NUM_SLOTS-1:0] active_mask;
    logic                 busy;
    logic [9:0]           pixel_x;
    logic [9:0]           pixel_y;
    logic                 video_on;
    logic [4:0]           rom_row;
    logic [3:0]           rom_col;
    logic [11:0]          rom_color;
    logic [11:0]          pix_color;
    logic                 pix_valid;

    modport master (
        output frame_tick, fire_req, fire_x, fire_y, hit_clear,
               pixel_x, pixel_y, video_on, rom_color,
        input  fire_ack, active_mask, busy, rom_row, rom_col,
               pix_color, pix_valid
    );

    modport slave (
        input  frame_tick, fire_req, fire_x, fire_y, hit_clear,
               pixel_x, pixel_y, video_on, rom_color,
        output fire_ack, active_mask, busy, rom_row, rom_col,
               pix_color, pix_valid
    );
endinterface

// File: rtl/projectile_scheduler.sv
// -----------------------------------------------------------------------------
// projectile_scheduler
//
// Purpose: keeps up to NUM_SLOTS live projectiles that all share one 20x10
// sprite ROM. Allocates slots on fire requests, moves every projectile up by
// SPEED once per frame (retiring those that leave the top of the screen),
// kills slots flagged by the collision logic, and for every VGA pixel picks
// the owning projectile, addresses the sprite ROM and returns a color/valid
// pair aligned two cycles behind pixel_x/pixel_y.
//
// Ports:
//   clk     system clock (single domain)
//   rst_n   asynchronous active-low reset
//   bus     projectile_scheduler_if.slave (fire handshake, hit_clear,
//           frame_tick/busy/active_mask, pixel/video_on in, ROM address out,
//           rom_color in, pix_color/pix_valid out)
//
// Build option:
//   PROJ_COLOR_KEY_EN  when defined, ROM color 12'hFFF is transparent
//                      (pix_valid low, pix_color 0); otherwise the whole
//                      sprite box is drawn, white included.
// -----------------------------------------------------------------------------
module projectile_scheduler #(
    parameter int NUM_SLOTS = 4,
    parameter int SPRITE_W  = 10,
    parameter int SPRITE_H  = 20,
    parameter int SPEED     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    projectile_scheduler_if.slave bus
);

    localparam int               IDX_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_SLOTS - 1);
    localparam logic [9:0]       SPEED_V    = 10'(SPEED);
    localparam logic [9:0]       SPRITE_W_V = 10'(SPRITE_W);
    localparam logic [9:0]       SPRITE_H_V = 10'(SPRITE_H);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_UPDATE = 1'b1
    } state_t;

    // Offsets are unsigned: a pixel left of / above the sprite wraps to a
    // large value and fails the box test without a separate sign check.
    function automatic logic in_box(input logic [9:0] dx, input logic [9:0] dy);
        return (dx < SPRITE_W_V) && (dy < SPRITE_H_V);
    endfunction

    function automatic logic [NUM_SLOTS-1:0] lowest_one(input logic [NUM_SLOTS-1:0] v);
        logic [NUM_SLOTS-1:0] oh;
        oh = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (v[i]) begin
                oh    = '0;
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    // Control state
    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 fire_ack_q;
    logic [NUM_SLOTS-1:0] active_q;

    // Slot positions
    logic [9:0]           slot_x_q [NUM_SLOTS];
    logic [9:0]           slot_y_q [NUM_SLOTS];

    // Decisions for this cycle
    logic                 alloc_en;
    logic                 upd_en;
    logic [NUM_SLOTS-1:0] free_mask;
    logic [NUM_SLOTS-1:0] alloc_oh;

    // A slot being cleared this cycle is never a candidate: for active slots
    // this is simply the pre-clear free mask, and it keeps a stray clear on an
    // idle slot from acking a request into a slot that dies on the same edge.
    assign free_mask = ~active_q & ~bus.hit_clear;
    assign alloc_oh  = lowest_one(free_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        alloc_en = 1'b0;
        upd_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // The ack guard keeps a still-high request in the ack cycle
                // from taking a second slot.
                alloc_en = bus.fire_req && !fire_ack_q && (|free_mask);
                if (bus.frame_tick) begin
                    state_d = S_UPDATE;
                    idx_d   = '0;
                end
            end
            S_UPDATE: begin
                upd_en = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fire_ack_q <= 1'b0;
            active_q   <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_x_q[i] <= '0;
                slot_y_q[i] <= '0;
            end
        end else begin
            fire_ack_q <= alloc_en;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (alloc_en && alloc_oh[i]) begin
                    slot_x_q[i] <= bus.fire_x;
                    slot_y_q[i] <= bus.fire_y;
                    active_q[i] <= 1'b1;
                end else if (upd_en && (idx_q == IDX_W'(i)) && active_q[i] && !bus.hit_clear[i]) begin
                    if (slot_y_q[i] < SPEED_V) begin
                        active_q[i] <= 1'b0;
                    end else begin
                        slot_y_q[i] <= slot_y_q[i] - SPEED_V;
                    end
                end
                if (bus.hit_clear[i]) begin
                    active_q[i] <= 1'b0;
                end
            end
        end
    end

    // ---- Stage 0: per-slot offsets and lowest-index hit (combinational) ----
    logic [9:0] dx_all [NUM_SLOTS];
    logic [9:0] dy_all [NUM_SLOTS];
    logic       hit_p0;
    logic [4:0] row_p0;
    logic [3:0] col_p0;

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            dx_all[i] = bus.pixel_x - slot_x_q[i];
            dy_all[i] = bus.pixel_y - slot_y_q[i];
        end
    end

    always_comb begin
        hit_p0 = 1'b0;
        row_p0 = '0;
        col_p0 = '0;
        // Walk from the top index down so the lowest hitting slot is the last
        // one to write the selection.
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (active_q[i] && bus.video_on && in_box(dx_all[i], dy_all[i])) begin
                hit_p0 = 1'b1;
                row_p0 = dy_all[i][4:0];
                col_p0 = dx_all[i][3:0];
            end
        end
    end

    // ---- Stage 1: registered ROM address, held when nothing is hit ----
    logic [4:0] rom_row_p1;
    logic [3:0] rom_col_p1;
    logic       vld_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_row_p1 <= '0;
            rom_col_p1 <= '0;
            vld_p1     <= 1'b0;
        end else begin
            vld_p1 <= hit_p0;
            if (hit_p0) begin
                rom_row_p1 <= row_p0;
                rom_col_p1 <= col_p0;
            end
        end
    end

    // ---- Stage 2: hit aligned with the ROM's registered color ----
    logic vld_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
        end
    end

    logic pix_valid_p2;

`ifdef PROJ_COLOR_KEY_EN
    assign pix_valid_p2 = vld_p2 && (bus.rom_color != 12'hFFF);
`else
    assign pix_valid_p2 = vld_p2;
`endif

    assign bus.pix_valid   = pix_valid_p2;
    assign bus.pix_color   = pix_valid_p2 ? bus.rom_color : 12'h000;
    assign bus.rom_row     = rom_row_p1;
    assign bus.rom_col     = rom_col_p1;
    assign bus.fire_ack    = fire_ack_q;
    assign bus.active_mask = active_q;
    assign bus.busy        = (state_q == S_UPDATE);

endmodule

// File: tb/tb_projectile_scheduler.sv
module tb_projectile_scheduler;

    localparam int NS = 4;

`ifdef PROJ_COLOR_KEY_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    projectile_scheduler_if #(.NUM_SLOTS(NS)) bus ();

    projectile_scheduler #(
        .NUM_SLOTS(NS),
        .SPRITE_W (10),
        .SPRITE_H (20),
        .SPEED    (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Sprite ROM model: one registered cycle from address to data.
    function automatic logic [11:0] rom_fn(input logic [4:0] r, input logic [3:0] c);
        if (r == 5'd0 && c == 4'd0) return 12'hFFF;
        if (r == 5'd15 && c == 4'd4) return 12'h555;
        return {3'b010, r, c};
    endfunction

    logic [11:0] rom_q;
    always_ff @(posedge clk) rom_q <= rom_fn(bus.rom_row, bus.rom_col);
    assign bus.rom_color = rom_q;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       von;
        logic       hit;
        logic [4:0] row;
        logic [3:0] col;
    } vec_t;

    typedef struct {
        int         idx;
        logic       v;
        logic [11:0] c;
    } exp_t;

    vec_t vt [19];
    exp_t sb [$];
    logic [4:0] m_row = '0;
    logic [3:0] m_col = '0;

    task automatic setv(input int i, input int x, input int y, input bit von,
                        input bit hit, input int row, input int col);
        vt[i].x   = 10'(x);
        vt[i].y   = 10'(y);
        vt[i].von = von;
        vt[i].hit = hit;
        vt[i].row = 5'(row);
        vt[i].col = 4'(col);
    endtask

    task automatic pop_cmp();
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("vec%0d pix_valid", e.idx), bus.pix_valid, e.v);
        chk($sformatf("vec%0d pix_color", e.idx), bus.pix_color, e.c);
    endtask

    task automatic run_vectors(input int lo, input int hi);
        exp_t e;
        logic [4:0] row_prev;
        logic [3:0] col_prev;
        for (int k = lo; k <= hi; k++) begin
            @(posedge clk);
            #1;
            bus.pixel_x  = vt[k].x;
            bus.pixel_y  = vt[k].y;
            bus.video_on = vt[k].von;
            row_prev = m_row;
            col_prev = m_col;
            if (vt[k].hit) begin
                m_row = vt[k].row;
                m_col = vt[k].col;
            end
            e.idx = k;
            e.c   = vt[k].hit ? rom_fn(vt[k].row, vt[k].col) : 12'h000;
            e.v   = vt[k].hit && !(KEY_EN && e.c == 12'hFFF);
            if (!e.v) e.c = 12'h000;
            sb.push_back(e);
            @(negedge clk);
            chk($sformatf("vec%0d rom_row", k), bus.rom_row, row_prev);
            chk($sformatf("vec%0d rom_col", k), bus.rom_col, col_prev);
            if (sb.size() > 2) pop_cmp();
        end
        for (int d = 0; d < 2; d++) begin
            @(posedge clk);
            #1;
            bus.video_on = 1'b0;
            @(negedge clk);
            if (d == 0) begin
                chk("drain rom_row", bus.rom_row, m_row);
                chk("drain rom_col", bus.rom_col, m_col);
            end
            pop_cmp();
        end
    endtask

    task automatic do_fire(input int x, input int y, input logic [NS-1:0] exp_mask, input string name);
        logic got;
        got = 1'b0;
        @(posedge clk);
        #1;
        bus.fire_req = 1'b1;
        bus.fire_x   = 10'(x);
        bus.fire_y   = 10'(y);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.fire_ack) begin
                got = 1'b1;
                break;
            end
        end
        chk({name, " ack"}, got, 1);
        chk({name, " mask"}, bus.active_mask, exp_mask);
        @(posedge clk);
        #1;
        bus.fire_req = 1'b0;
        @(negedge clk);
        chk({name, " ack pulse"}, bus.fire_ack, 0);
    endtask

    task automatic do_frame(input bit extra, input logic [NS-1:0] exp_mask, input string name);
        int   cnt;
        logic done;
        cnt  = 0;
        done = 1'b0;
        @(negedge clk);
        bus.frame_tick = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) bus.frame_tick = 1'b0;
            if (extra && c == 1) bus.frame_tick = 1'b1;
            if (extra && c == 2) bus.frame_tick = 1'b0;
            if (bus.busy) begin
                cnt++;
            end else begin
                done = 1'b1;
                break;
            end
        end
        chk({name, " busy ends"}, done, 1);
        chk({name, " busy cycles"}, cnt, NS);
        chk({name, " mask"}, bus.active_mask, exp_mask);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " fire_ack"}, bus.fire_ack, 0);
        chk({name, " active_mask"}, bus.active_mask, 0);
        chk({name, " busy"}, bus.busy, 0);
        chk({name, " rom_row"}, bus.rom_row, 0);
        chk({name, " rom_col"}, bus.rom_col, 0);
        chk({name, " pix_color"}, bus.pix_color, 0);
        chk({name, " pix_valid"}, bus.pix_valid, 0);
    endtask

    initial begin
        logic seen;

        // Slots: s0(100,400) s1(198,190) s2(300,100) s3(195,185)
        setv(0, 100, 400, 1, 1, 0, 0);
        setv(1, 104, 415, 1, 1, 15, 4);
        setv(2, 99, 400, 1, 0, 0, 0);
        setv(3, 110, 400, 1, 0, 0, 0);
        setv(4, 109, 419, 1, 1, 19, 9);
        setv(5, 109, 420, 1, 0, 0, 0);
        setv(6, 200, 200, 1, 1, 10, 2);
        setv(7, 196, 186, 1, 1, 1, 1);
        setv(8, 100, 400, 0, 0, 0, 0);
        setv(9, 305, 110, 1, 1, 10, 5);
        // After one frame: s0(100,396) s1(60,56) s2(50,46) s3(195,181)
        setv(10, 100, 396, 1, 1, 0, 0);
        setv(11, 100, 400, 1, 1, 4, 0);
        setv(12, 100, 395, 1, 0, 0, 0);
        setv(13, 62, 60, 1, 1, 4, 2);
        setv(14, 195, 200, 1, 1, 19, 0);
        setv(15, 195, 201, 1, 0, 0, 0);
        // After second frame: s0(100,392) s1(30,0) s2 retired s3(195,177)
        setv(16, 31, 2, 1, 1, 2, 1);
        setv(17, 20, 3, 1, 0, 0, 0);
        setv(18, 100, 392, 1, 1, 0, 0);

        bus.frame_tick = 1'b0;
        bus.fire_req   = 1'b0;
        bus.fire_x     = '0;
        bus.fire_y     = '0;
        bus.hit_clear  = '0;
        bus.pixel_x    = '0;
        bus.pixel_y    = '0;
        bus.video_on   = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        do_fire(100, 400, 4'b0001, "fire0");
        do_fire(198, 190, 4'b0011, "fire1");
        do_fire(300, 100, 4'b0111, "fire2");
        do_fire(195, 185, 4'b1111, "fire3");

        run_vectors(0, 9);

        // Fifth request held while full; freed by hit_clear[2].
        @(negedge clk);
        bus.fire_req = 1'b1;
        bus.fire_x   = 10'd50;
        bus.fire_y   = 10'd50;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.fire_ack) seen = 1'b1;
        end
        chk("full no ack", seen, 0);
        chk("full mask", bus.active_mask, 4'b1111);
        bus.hit_clear = 4'b0100;
        @(negedge clk);
        bus.hit_clear = '0;
        chk("clear2 no ack", bus.fire_ack, 0);
        chk("clear2 mask", bus.active_mask, 4'b1011);
        @(negedge clk);
        chk("clear2 ack", bus.fire_ack, 1);
        chk("clear2 refill mask", bus.active_mask, 4'b1111);
        bus.fire_req = 1'b0;
        @(negedge clk);
        chk("clear2 ack pulse", bus.fire_ack, 0);

        // Clear and request in the same cycle: slot 1 not reused until next cycle.
        bus.fire_req  = 1'b1;
        bus.fire_x    = 10'd60;
        bus.fire_y    = 10'd60;
        bus.hit_clear = 4'b0010;
        @(negedge clk);
        bus.hit_clear = '0;
        chk("clear1 same-cycle no ack", bus.fire_ack, 0);
        chk("clear1 mask", bus.active_mask, 4'b1101);
        @(negedge clk);
        chk("clear1 ack", bus.fire_ack, 1);
        chk("clear1 refill mask", bus.active_mask, 4'b1111);
        bus.fire_req = 1'b0;
        @(negedge clk);
        chk("clear1 ack pulse", bus.fire_ack, 0);

        do_frame(1'b0, 4'b1111, "frame1");
        run_vectors(10, 15);

        // Boundary: y==SPEED survives at 0, y<SPEED retires; extra tick ignored.
        @(negedge clk);
        bus.hit_clear = 4'b0110;
        @(negedge clk);
        bus.hit_clear = '0;
        chk("clear12 mask", bus.active_mask, 4'b1001);
        do_fire(30, 4, 4'b1011, "fire y4");
        do_fire(20, 3, 4'b1111, "fire y3");
        do_frame(1'b1, 4'b1011, "frame2");
        run_vectors(16, 18);

        // Asynchronous reset in the middle of an update.
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        chk("pre-reset busy", bus.busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset busy", bus.busy, 0);
        chk("post-reset mask", bus.active_mask, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
